// File: rtl/readout_pkg.sv
// Shared types and defaults for the readout scan engine.
//   scan_state_t     : scan FSM state encoding
//   readout_sample_t : one tagged readout sample at the default widths
//   idx_width()      : index width helper that never returns 0
package readout_pkg;

  localparam int unsigned DEF_ADDR_W   = 5;
  localparam int unsigned DEF_DATA_W   = 24;
  localparam int unsigned DEF_REGION_W = 5;
  localparam int unsigned DEF_SWEEP_W  = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    OUTPUT = 2'd2,
    DONE   = 2'd3
  } scan_state_t;

  typedef struct packed {
    logic [DEF_DATA_W-1:0]   data;
    logic [DEF_REGION_W-1:0] region;
    logic [DEF_ADDR_W-1:0]   addr;
    logic [DEF_SWEEP_W-1:0]  sweep;
  } readout_sample_t;

  // Width needed to index n items, at least 1 bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/readout_scan_ctrl_if.sv
// Sample stream port of the readout scan engine (valid/ready plus tags).
//   valid/ready : handshake, transfer when both high on a clock edge
//   data        : captured region data word
//   region      : binary region index of the sample
//   addr        : region address of the sample
//   sweep       : sweep number of the sample
interface readout_scan_ctrl_if
  import readout_pkg::*;
#(
  parameter int unsigned DATA_W   = DEF_DATA_W,
  parameter int unsigned REGION_W = DEF_REGION_W,
  parameter int unsigned ADDR_W   = DEF_ADDR_W,
  parameter int unsigned SWEEP_W  = DEF_SWEEP_W
);

  logic                valid;
  logic                ready;
  logic [DATA_W-1:0]   data;
  logic [REGION_W-1:0] region;
  logic [ADDR_W-1:0]   addr;
  logic [SWEEP_W-1:0]  sweep;

  modport master (output valid, data, region, addr, sweep, input ready);
  modport slave  (input valid, data, region, addr, sweep, output ready);

endinterface

// File: rtl/readout_mask_next.sv
// Combinational next-set-bit finder over a region mask.
//   mask     : region enable bits
//   idx      : current index, signed; -1 selects the lowest set bit
//   next_idx : lowest set bit above idx, or lowest set bit overall on wrap
//   wrap     : no set bit above idx
module readout_mask_next
  import readout_pkg::*;
#(
  parameter int unsigned NUM_REGIONS = 17,
  localparam int unsigned RW = idx_width(NUM_REGIONS)
) (
  input  logic [NUM_REGIONS-1:0] mask,
  input  logic signed [RW:0]     idx,
  output logic [RW-1:0]          next_idx,
  output logic                   wrap
);

  logic [RW-1:0] low;
  logic [RW-1:0] above;
  logic          found;

  // Descending scan so the last hit is the lowest qualifying bit.
  always_comb begin
    low   = '0;
    above = '0;
    found = 1'b0;
    for (int i = NUM_REGIONS - 1; i >= 0; i--) begin
      if (mask[i]) begin
        low = RW'(i);
        if ($signed({1'b0, RW'(i)}) > idx) begin
          above = RW'(i);
          found = 1'b1;
        end
      end
    end
    next_idx = found ? above : low;
    wrap     = !found;
  end

endmodule

// File: rtl/readout_scan_ctrl.sv
// Scan/readout engine: sweeps enabled regions over addresses 0..NUM_ADDR-1,
// waits SETTLE_CYC cycles after each address change, captures the selected
// lane and streams it with region/address/sweep tags.
//   clk, rst          : clock, synchronous active-high reset
//   start_i, abort_i  : start pulse (IDLE only), abort (SETTLE/OUTPUT only)
//   cont_i, mask_i    : continuous mode and region enables, latched at start
//   addr_o, data_i    : address broadcast and packed region data lanes
//   out_if            : sample stream (master side)
//   busy_o, done_o    : not-IDLE flag, end-of-scan/abort pulse
module readout_scan_ctrl
  import readout_pkg::*;
#(
  parameter int unsigned NUM_REGIONS = 17,
  parameter int unsigned ADDR_W      = DEF_ADDR_W,
  parameter int unsigned DATA_W      = DEF_DATA_W,
  parameter int unsigned NUM_ADDR    = 20,
  parameter int unsigned SETTLE_CYC  = 4,
  parameter int unsigned SWEEP_W     = DEF_SWEEP_W
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start_i,
  input  logic                          abort_i,
  input  logic                          cont_i,
  input  logic [NUM_REGIONS-1:0]        mask_i,
  output logic [ADDR_W-1:0]             addr_o,
  input  logic [NUM_REGIONS*DATA_W-1:0] data_i,
  readout_scan_ctrl_if.master           out_if,
  output logic                          busy_o,
  output logic                          done_o
);

  localparam int unsigned RW    = idx_width(NUM_REGIONS);
  localparam int unsigned CNT_W = idx_width(SETTLE_CYC);

  scan_state_t state, state_nxt;

  logic [NUM_REGIONS-1:0] mask_q;
  logic                   cont_q;
  logic [RW-1:0]          region;
  logic [ADDR_W-1:0]      addr;
  logic [SWEEP_W-1:0]     sweep;
  logic [CNT_W-1:0]       cnt;

  logic                   valid;
  logic [DATA_W-1:0]      smp_data;
  logic [RW-1:0]          smp_region;
  logic [ADDR_W-1:0]      smp_addr;
  logic [SWEEP_W-1:0]     smp_sweep;

  logic [NUM_REGIONS-1:0] find_mask;
  logic signed [RW:0]     find_idx;
  logic [RW-1:0]          find_next;
  logic                   find_wrap;

  logic [DATA_W-1:0]      lane;
  logic                   settle_last;
  logic                   addr_last;
  logic                   do_start;
  logic                   do_capture;
  logic                   do_adv;
  logic                   enter_done;

  assign settle_last = (cnt == CNT_W'(SETTLE_CYC - 1));
  assign addr_last   = (addr == ADDR_W'(NUM_ADDR - 1));

  // In IDLE search the live mask from -1 (lowest bit); otherwise step from the current region.
  always_comb begin
    find_mask = mask_q;
    find_idx  = $signed({1'b0, region});
    if (state == IDLE) begin
      find_mask = mask_i;
      find_idx  = '1;
    end
  end

  readout_mask_next #(.NUM_REGIONS(NUM_REGIONS)) u_mask_next (
    .mask     (find_mask),
    .idx      (find_idx),
    .next_idx (find_next),
    .wrap     (find_wrap)
  );

  // Lane mux for the current region.
  always_comb begin
    lane = '0;
    for (int r = 0; r < NUM_REGIONS; r++) begin
      if (region == RW'(r)) lane = data_i[r*DATA_W +: DATA_W];
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic; abort wins over a same-cycle handshake.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (start_i) state_nxt = (mask_i != '0) ? SETTLE : DONE;
      end
      SETTLE: begin
        if (abort_i)          state_nxt = DONE;
        else if (settle_last) state_nxt = OUTPUT;
      end
      OUTPUT: begin
        if (abort_i) begin
          state_nxt = DONE;
        end else if (valid && out_if.ready) begin
          state_nxt = (addr_last && find_wrap && !cont_q) ? DONE : SETTLE;
        end
      end
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath control strobes decoded from state.
  always_comb begin
    do_start   = 1'b0;
    do_capture = 1'b0;
    do_adv     = 1'b0;
    enter_done = 1'b0;
    unique case (state)
      IDLE:    do_start   = start_i && (mask_i != '0);
      SETTLE:  do_capture = !abort_i && settle_last;
      OUTPUT:  do_adv     = !abort_i && valid && out_if.ready;
      default: ;
    endcase
    if (state != DONE && state_nxt == DONE) enter_done = 1'b1;
  end

  // Counters, latched configuration and the registered sample/status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      mask_q     <= '0;
      cont_q     <= 1'b0;
      region     <= '0;
      addr       <= '0;
      sweep      <= '0;
      cnt        <= '0;
      valid      <= 1'b0;
      smp_data   <= '0;
      smp_region <= '0;
      smp_addr   <= '0;
      smp_sweep  <= '0;
      busy_o     <= 1'b0;
      done_o     <= 1'b0;
    end else begin
      cnt <= (state == SETTLE && state_nxt == SETTLE) ? CNT_W'(cnt + 1'b1) : '0;

      if (do_start) begin
        mask_q <= mask_i;
        cont_q <= cont_i;
        sweep  <= '0;
        region <= find_next;
        addr   <= '0;
      end

      if (do_adv) begin
        if (addr_last) begin
          addr   <= '0;
          region <= find_next;
          if (find_wrap) sweep <= SWEEP_W'(sweep + 1'b1);
        end else begin
          addr <= ADDR_W'(addr + 1'b1);
        end
      end

      if (enter_done) addr <= '0;

      if (do_capture) begin
        smp_data   <= lane;
        smp_region <= region;
        smp_addr   <= addr;
        smp_sweep  <= sweep;
      end

      valid  <= (state_nxt == OUTPUT);
      busy_o <= (state_nxt != IDLE);
      done_o <= (state_nxt == DONE);
    end
  end

  assign addr_o        = addr;
  assign out_if.valid  = valid;
  assign out_if.data   = smp_data;
  assign out_if.region = smp_region;
  assign out_if.addr   = smp_addr;
  assign out_if.sweep  = smp_sweep;

endmodule
